vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical counters, hsync/vsync, active-video flag, pixel coordinates and frame/line start strobes. Sits directly downstream of the clock divider and consumes its 25 MHz pixel rate as a one-clk-wide enable strobe, so the whole block runs on the 100 MHz master clock. Its outputs feed the pixel/colour generator and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/mod_counter.sv | 33 +++
 rtl/vga_sync_gen.sv | 77 +++++++
 tb/tb_vga_sync_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants, reused by the sync generator,
// pixel generator and benches.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;
  localparam int DEF_CNT_W    = 10;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Inclusive window test on a zero-extended counter value.
  function automatic logic in_win(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable and configurable reset value. Exposes the
// next-state value so callers can register outputs coherent with the count.
module mod_counter #(
  parameter int CNT_W   = 10,
  parameter int MODULUS = 800,
  parameter int RST_VAL = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] nxt,
  output logic             wrap
);

  assign wrap = (cnt == CNT_W'(MODULUS - 1));

  always_comb begin
    nxt = cnt;
    if (en) begin
      nxt = wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(RST_VAL);
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters advance on the pixel strobe, and all
// sync/active/strobe outputs are registered from the next-state counts.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [CNT_W-1:0] hcnt, vcnt, h_nxt, v_nxt;
  logic             h_wrap, v_wrap;

  mod_counter #(.CNT_W(CNT_W), .MODULUS(HT), .RST_VAL(HT - 1)) u_hcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_en),
    .cnt  (hcnt),
    .nxt  (h_nxt),
    .wrap (h_wrap)
  );

  mod_counter #(.CNT_W(CNT_W), .MODULUS(VT), .RST_VAL(VT - 1)) u_vcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_en & h_wrap),
    .cnt  (vcnt),
    .nxt  (v_nxt),
    .wrap (v_wrap)
  );

  // nxt equals cnt while pix_en is low, so level outputs hold on stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= in_win(int'(h_nxt), HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync       <= in_win(int'(v_nxt), VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      video_on    <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      line_start  <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
    end
  end

  assign px_x = hcnt;
  assign px_y = vcnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default horizontal timing, vertical timing
// shrunk (6/2/2/3, total 13 lines) so whole frames fit in a short run.
module tb_vga_sync_gen;

  localparam int CNT_W = 10;
  localparam int HT = 800;
  localparam int VT = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_en = 1'b0;
  logic             hsync, vsync, video_on, line_start, frame_start;
  logic [CNT_W-1:0] px_x, px_y;

  int n_checks = 0;
  int n_pass   = 0;

  vga_sync_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .px_x       (px_x),
    .px_y       (px_y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic vo;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    pix_en = 1'b1;
    repeat (n) tick();
    pix_en = 1'b0;
  endtask

  task automatic do_reset();
    pix_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [24:0] pack(int x, int y, logic hs, logic vs, logic vo,
                                       logic ls, logic fs);
    return {CNT_W'(x), CNT_W'(y), hs, vs, vo, ls, fs};
  endfunction

  function automatic logic [24:0] dut_state();
    return {px_x, px_y, hsync, vsync, video_on, line_start, frame_start};
  endfunction

  initial begin
    int cur, idx, cnt_ls, cnt_fs, cnt_hs, cnt_vs, cnt_vo, bad, last_ls, gap;
    logic [24:0] prev;

    tbl[0]  = '{0,   0, 1, 1, 1};
    tbl[1]  = '{639, 0, 1, 1, 1};
    tbl[2]  = '{640, 0, 1, 1, 0};
    tbl[3]  = '{655, 0, 1, 1, 0};
    tbl[4]  = '{656, 0, 0, 1, 0};
    tbl[5]  = '{751, 0, 0, 1, 0};
    tbl[6]  = '{752, 0, 1, 1, 0};
    tbl[7]  = '{799, 0, 1, 1, 0};
    tbl[8]  = '{0,   1, 1, 1, 1};
    tbl[9]  = '{639, 5, 1, 1, 1};
    tbl[10] = '{0,   6, 1, 1, 0};
    tbl[11] = '{799, 7, 1, 1, 0};
    tbl[12] = '{0,   8, 1, 0, 0};
    tbl[13] = '{700, 8, 0, 0, 0};
    tbl[14] = '{799, 9, 1, 0, 0};
    tbl[15] = '{0,  10, 1, 1, 0};
    tbl[16] = '{799,12, 1, 1, 0};

    // Reset, then 10 idle clocks: last blanked pixel, syncs inactive.
    do_reset();
    repeat (10) tick();
    check("reset_idle", dut_state(), pack(799, 12, 1, 1, 0, 0, 0));

    // Table walk: position index y*HT+x, reset position is index -1.
    cur = -1;
    for (int i = 0; i < 17; i++) begin
      idx = tbl[i].y * HT + tbl[i].x;
      advance(idx - cur);
      cur = idx;
      check($sformatf("vec%0d_(%0d,%0d)", i, tbl[i].x, tbl[i].y), dut_state(),
            pack(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].vo,
                 tbl[i].x == 0, (tbl[i].x == 0) && (tbl[i].y == 0)));
    end
    advance(1);
    check("frame_wrap", dut_state(), pack(0, 0, 1, 1, 1, 1, 1));

    // Full frame with pix_en tied high: aggregate counts and coherence.
    do_reset();
    cnt_ls = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_vo = 0; bad = 0;
    last_ls = -1; gap = 0;
    pix_en = 1'b1;
    for (int c = 0; c < HT * VT; c++) begin
      tick();
      if (line_start) begin
        if (last_ls >= 0 && c - last_ls != HT) gap++;
        last_ls = c;
        cnt_ls++;
      end
      if (frame_start) begin
        cnt_fs++;
        if (!line_start || px_x != 0 || px_y != 0) bad++;
      end
      if (!hsync) cnt_hs++;
      if (!vsync) cnt_vs++;
      if (video_on) cnt_vo++;
      if (hsync != !(px_x >= 656 && px_x <= 751)) bad++;
      if (vsync != !(px_y >= 8 && px_y <= 9)) bad++;
      if (video_on != (px_x < 640 && px_y < 6)) bad++;
    end
    pix_en = 1'b0;
    check("frame_line_starts", cnt_ls, VT);
    check("frame_frame_starts", cnt_fs, 1);
    check("frame_line_period", gap, 0);
    check("frame_hsync_low", cnt_hs, 96 * VT);
    check("frame_vsync_low", cnt_vs, 2 * HT);
    check("frame_video_on", cnt_vo, 640 * 6);
    check("frame_coherence", bad, 0);

    // Divider rate: pix_en one clk in four for two lines.
    do_reset();
    cnt_ls = 0; bad = 0; last_ls = -1; gap = 0;
    for (int c = 0; c < 4 * 2 * HT; c++) begin
      prev = dut_state();
      pix_en = (c % 4 == 0);
      tick();
      if (!pix_en && dut_state()[24:2] != prev[24:2]) bad++;
      if (!pix_en && (line_start || frame_start)) bad++;
      if (line_start) begin
        if (last_ls >= 0) gap = c - last_ls;
        last_ls = c;
        cnt_ls++;
      end
    end
    pix_en = 1'b0;
    check("div_line_starts", cnt_ls, 2);
    check("div_line_period", gap, 4 * HT);
    check("div_hold", bad, 0);

    // Asynchronous reset mid-frame at (300,4).
    do_reset();
    advance(4 * HT + 300 + 1);
    check("pre_reset_pos", dut_state(), pack(300, 4, 1, 1, 1, 0, 0));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", dut_state(), pack(799, 12, 1, 1, 0, 0, 0));
    tick();
    rst_n = 1'b1;
    tick();
    advance(1);
    check("post_reset_first", dut_state(), pack(0, 0, 1, 1, 1, 1, 1));

    // Stall at (0,0) right after frame_start.
    bad = 0;
    repeat (50) begin
      tick();
      if (dut_state() != pack(0, 0, 1, 1, 1, 0, 0)) bad++;
    end
    check("stall_at_origin", bad, 0);
    advance(1);
    check("resume_after_stall", dut_state(), pack(1, 0, 1, 1, 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
